hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameters SHALL be: REG_AW, 5, register-index width; LOAD_LAT, 1, load-use stall cycles (legal 1..7); CNT_W, 3, stall-counter width.
REQ-002 Clock and reset SHALL be: clk in 1, rising-edge clock; rstn in 1, synchronous active-low reset.
REQ-003 ID-stage inputs SHALL be: id_rs1 in REG_AW; id_rs2 in REG_AW; id_rs1_used in 1; id_rs2_used in 1.
REQ-004 EX-stage inputs SHALL be: ex_rd in REG_AW; ex_regwrite in 1; ex_memread in 1; ex_redirect in 1, taken branch/jump resolved in EX; ex_mc_start in 1, multicycle op entered EX; ex_mc_done in 1, multicycle result valid.
REQ-005 MEM-stage inputs SHALL be: mem_rd in REG_AW; mem_regwrite in 1.
REQ-006 Outputs SHALL be: pc_stall out 1; ifid_stall out 1; idex_bubble out 1, insert NOP into ID/EX; ifid_flush out 1; idex_flush out 1; exmem_hold out 1; busy out 1, state not IDLE; stall_cnt out CNT_W, remaining load stall cycles.

Function
REQ-007 A RAW match SHALL require: source-used flag set, writer regwrite set, writer rd nonzero, and rd equal to the source index; rd==0 SHALL never stall.
REQ-008 FSM states SHALL be IDLE, LOAD_STALL and MC_WAIT; outputs SHALL be combinational from state, counter and current inputs (Mealy).
REQ-009 Priority in IDLE SHALL be: ex_redirect > load-use RAW > ex_mc_start.
REQ-010 IDLE with ex_redirect: ifid_flush=idex_flush=1 in the same cycle, all stall outputs 0, next state IDLE; a simultaneous load-use is discarded.
REQ-011 IDLE with load-use (EX RAW with ex_memread): pc_stall=ifid_stall=idex_bubble=1 in that cycle; if LOAD_LAT>1, next state LOAD_STALL with stall_cnt=LOAD_LAT-1, else stay IDLE.
REQ-012 LOAD_STALL SHALL assert pc_stall, ifid_stall and idex_bubble, decrement stall_cnt each cycle, and return to IDLE after the cycle in which stall_cnt==1; total stall SHALL be exactly LOAD_LAT cycles.
REQ-013 IDLE with ex_mc_start and no higher-priority event: pc_stall=ifid_stall=exmem_hold=1 from that cycle; next state MC_WAIT.
REQ-014 MC_WAIT SHALL hold pc_stall, ifid_stall and exmem_hold until the cycle ex_mc_done=1, in which all three SHALL be 0, then return to IDLE; ex_mc_done in the ex_mc_start cycle SHALL produce zero stall.
REQ-015 ex_redirect in LOAD_STALL or MC_WAIT SHALL be ignored (cannot occur by pipeline construction; the bench flags it as an error).
REQ-016 stall_cnt SHALL be 0 in every state other than LOAD_STALL; busy SHALL be 1 in LOAD_STALL and MC_WAIT.

Reset
REQ-017 While rstn==0 at a clk edge: state IDLE, stall_cnt 0; all outputs SHALL read 0 during reset regardless of inputs.
REQ-018 Reset asserted mid-LOAD_STALL or mid-MC_WAIT SHALL abort the stall; the first cycle after release SHALL be IDLE.

Configuration
REQ-019 With HAZARD_FWD_EN defined, only load-use RAW (REQ-011) and multicycle stalls SHALL occur; MEM-stage inputs SHALL be unused.
REQ-020 Without HAZARD_FWD_EN, any RAW against the EX or MEM writer SHALL assert pc_stall, ifid_stall and idex_bubble combinationally in IDLE, re-evaluated each cycle; LOAD_STALL SHALL never be entered; redirect and multicycle behaviour are unchanged.

Structure
REQ-021 Package hazard_pkg SHALL hold the FSM state enum and the default values of REG_AW, LOAD_LAT and CNT_W.
REQ-022 Sub-module hazard_cmp SHALL implement one RAW comparison (REQ-007), instantiated once per source/writer pair.

Verification
REQ-023 FWD_EN, LOAD_LAT=3: lw x5 in EX (ex_memread=1, ex_rd=5), id_rs1=5 used -> pc_stall high exactly 3 cycles, stall_cnt 0,2,1 then 0.
REQ-024 Same load-use with ex_redirect=1 in the same cycle -> ifid_flush=idex_flush=1 for 1 cycle, pc_stall 0, state IDLE.
REQ-025 ex_rd=0, ex_memread=1, id_rs1=0 used -> no stall.
REQ-026 ex_mc_start, ex_mc_done 5 cycles later -> pc_stall and exmem_hold high exactly 5 cycles, busy high 5 cycles.
REQ-027 rstn low on the 2nd cycle of a LOAD_LAT=4 stall -> all outputs 0 during reset, IDLE after release.
REQ-028 FWD_EN undefined: mem_regwrite=1, mem_rd=7, id_rs2=7 used -> stall 1 cycle; same with ex_rd=7, ex_regwrite=1 -> stall 2 cycles as instruction advances.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and default parameters for the pipeline hazard unit.
package hazard_pkg;

  localparam int unsigned REG_AW_DEF   = 5;
  localparam int unsigned LOAD_LAT_DEF = 1;
  localparam int unsigned CNT_W_DEF    = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MC_WAIT    = 2'd2
  } hz_state_e;

  // Pipeline control strobes produced by the hazard unit each cycle.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_hold;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-to-hazard-unit signal bundle; the pipeline is master, the hazard unit is slave.
interface hazard_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;

  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_redirect;
  logic              ex_mc_start;
  logic              ex_mc_done;

  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;

  logic              pc_stall;
  logic              ifid_stall;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_hold;
  logic              busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_rd, ex_regwrite, ex_memread, ex_redirect, ex_mc_start, ex_mc_done,
    output mem_rd, mem_regwrite,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
    input  exmem_hold, busy, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_rd, ex_regwrite, ex_memread, ex_redirect, ex_mc_start, ex_mc_done,
    input  mem_rd, mem_regwrite,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
    output exmem_hold, busy, stall_cnt
  );

endinterface

// File: rtl/hazard_cmp.sv
// One read-after-write check between an ID-stage source and a later-stage writer.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              src_used_i,
  input  logic [REG_AW-1:0] wr_rd_i,
  input  logic              wr_regwrite_i,
  output logic              match_o
);

  // x0 is hard-wired to zero, so a write to it can never create a dependency.
  assign match_o = src_used_i && wr_regwrite_i && (wr_rd_i != '0) && (wr_rd_i == src_i);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: flush on redirect, RAW stalls, multicycle-op hold.
// Build option HAZARD_FWD_EN: forwarding present, only load-use RAW stalls (LOAD_LAT cycles).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEF,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input logic     clk,
  input logic     rstn,
  hazard_if.slave hz
);

  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT - 1);

`ifdef HAZARD_FWD_EN
  localparam bit LOAD_FSM_EN = (LOAD_LAT > 1);
`else
  localparam bit LOAD_FSM_EN = 1'b0;
`endif

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hz_ctrl_t         ctrl;
  logic [CNT_W-1:0] cnt_out;
  logic             rs1_ex, rs2_ex;
  logic             data_haz;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs1_ex (
    .src_i        (hz.id_rs1),
    .src_used_i   (hz.id_rs1_used),
    .wr_rd_i      (hz.ex_rd),
    .wr_regwrite_i(hz.ex_regwrite),
    .match_o      (rs1_ex)
  );

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs2_ex (
    .src_i        (hz.id_rs2),
    .src_used_i   (hz.id_rs2_used),
    .wr_rd_i      (hz.ex_rd),
    .wr_regwrite_i(hz.ex_regwrite),
    .match_o      (rs2_ex)
  );

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load whose data is not back until MEM.
  assign data_haz = (rs1_ex | rs2_ex) & hz.ex_memread;
`else
  logic rs1_mem, rs2_mem;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs1_mem (
    .src_i        (hz.id_rs1),
    .src_used_i   (hz.id_rs1_used),
    .wr_rd_i      (hz.mem_rd),
    .wr_regwrite_i(hz.mem_regwrite),
    .match_o      (rs1_mem)
  );

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs2_mem (
    .src_i        (hz.id_rs2),
    .src_used_i   (hz.id_rs2_used),
    .wr_rd_i      (hz.mem_rd),
    .wr_regwrite_i(hz.mem_regwrite),
    .match_o      (rs2_mem)
  );

  assign data_haz = rs1_ex | rs2_ex | rs1_mem | rs2_mem;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = '0;
    cnt_out = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (hz.ex_redirect) begin
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
        end else if (data_haz) begin
          ctrl.pc_stall    = 1'b1;
          ctrl.ifid_stall  = 1'b1;
          ctrl.idex_bubble = 1'b1;
          if (LOAD_FSM_EN) begin
            state_d = ST_LOAD_STALL;
            cnt_d   = LOAD_INIT;
          end
        end else if (hz.ex_mc_start && !hz.ex_mc_done) begin
          ctrl.pc_stall   = 1'b1;
          ctrl.ifid_stall = 1'b1;
          ctrl.exmem_hold = 1'b1;
          state_d         = ST_MC_WAIT;
        end
      end

      ST_LOAD_STALL: begin
        ctrl.pc_stall    = 1'b1;
        ctrl.ifid_stall  = 1'b1;
        ctrl.idex_bubble = 1'b1;
        cnt_out          = cnt_q;
        cnt_d            = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_MC_WAIT: begin
        if (hz.ex_mc_done) begin
          state_d = ST_IDLE;
        end else begin
          ctrl.pc_stall   = 1'b1;
          ctrl.ifid_stall = 1'b1;
          ctrl.exmem_hold = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are Mealy, so reset must mask them in the same cycle it is asserted.
    if (!rstn) begin
      ctrl    = '0;
      cnt_out = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_stall    = ctrl.pc_stall;
  assign hz.ifid_stall  = ctrl.ifid_stall;
  assign hz.idex_bubble = ctrl.idex_bubble;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_flush  = ctrl.idex_flush;
  assign hz.exmem_hold  = ctrl.exmem_hold;
  assign hz.busy        = rstn && (state_q != ST_IDLE);
  assign hz.stall_cnt   = cnt_out;

endmodule
